// File: rtl/pong_menu_pkg.sv
// Shared menu types, box geometry and default timing for the PONG front end.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pong_menu_pkg;

    // Top-level flow of the menu controller.
    typedef enum logic [1:0] {
        MENU    = 2'd0,
        CONFIRM = 2'd1,
        RUN     = 2'd2
    } menu_state_e;

    // Default timing, in frames (one frame per rising vsync edge).
    localparam int DEF_N_ITEMS        = 4;
    localparam int DEF_REPEAT_DELAY   = 30;
    localparam int DEF_REPEAT_RATE    = 6;
    localparam int DEF_BLINK_FRAMES   = 8;
    localparam int DEF_CONFIRM_FRAMES = 64;

    // Box geometry shared with the menu renderer. All boxes share one
    // column; rows are 100 lines tall on a 192-line pitch.
    localparam int BOX_X_MIN   = 362;
    localparam int BOX_X_MAX   = 674;
    localparam int BOX_Y0_MIN  = 46;
    localparam int BOX_Y0_MAX  = 146;
    localparam int BOX_Y1_MIN  = 238;
    localparam int BOX_Y1_MAX  = 338;
    localparam int BOX_Y2_MIN  = 430;
    localparam int BOX_Y2_MAX  = 530;
    localparam int BOX_Y3_MIN  = 622;
    localparam int BOX_Y3_MAX  = 722;

    // Top line of box idx, for renderers that prefer an index lookup.
    function automatic int box_y_min(input int idx);
        case (idx)
            0:       return BOX_Y0_MIN;
            1:       return BOX_Y1_MIN;
            2:       return BOX_Y2_MIN;
            default: return BOX_Y3_MIN;
        endcase
    endfunction

    // Bottom line of box idx.
    function automatic int box_y_max(input int idx);
        case (idx)
            0:       return BOX_Y0_MAX;
            1:       return BOX_Y1_MAX;
            2:       return BOX_Y2_MAX;
            default: return BOX_Y3_MAX;
        endcase
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Press detector plus hold/auto-repeat timer for one cursor direction.
// Latency: press and step are combinational from the current button level and frame tick.
// Backpressure: none; clr forces the hold timer back to zero whenever asserted.
module btn_repeat
    import pong_menu_pkg::*;
#(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic pclk,
    input  logic rst,
    input  logic btn_lvl,     // this direction's debounced level
    input  logic other_lvl,   // opposite direction's level
    input  logic frame_tick,
    input  logic clr,         // any press anywhere, or not in MENU
    output logic press,
    output logic step
);

    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = $clog2(REPEAT_RATE + 1);
    localparam logic [HW-1:0] HOLD_END = HW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_END = RW'(REPEAT_RATE - 1);

    logic          btn_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rate_q, rate_d;
    logic          held_alone;

    // Press is kept apart from the timer logic so clr can include it
    // without forming a combinational path back into this block.
    assign press      = btn_lvl & ~btn_q;
    assign held_alone = btn_lvl & ~other_lvl;

    // Hold timer: saturates at the delay, then a rate timer paces repeats.
    always_comb begin
        hold_d = hold_q;
        rate_d = rate_q;
        step   = 1'b0;
        if (!held_alone || clr || press) begin
            hold_d = '0;
            rate_d = '0;
        end else if (frame_tick) begin
            if (hold_q != HOLD_END) begin
                hold_d = hold_q + 1'b1;
                step   = (hold_d == HOLD_END);
            end else if (rate_q == RATE_END) begin
                rate_d = '0;
                step   = 1'b1;
            end else begin
                rate_d = rate_q + 1'b1;
            end
        end
    end

    // Level copy for edge detect and the two timers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            btn_q  <= 1'b0;
            hold_q <= '0;
            rate_q <= '0;
        end else begin
            btn_q  <= btn_lvl;
            hold_q <= hold_d;
            rate_q <= rate_d;
        end
    end

endmodule

// File: rtl/menu_ctrl.sv
// Menu controller: wrapped cursor over the menu boxes, MENU->CONFIRM->RUN flow with blink, game start.
// Latency: an input edge sampled at clock edge k is reflected on the registered outputs from cycle k+1.
// Backpressure: none; buttons are levels and every edge is acted on in the cycle it is seen.
module menu_ctrl
    import pong_menu_pkg::*;
#(
    parameter int N_ITEMS        = DEF_N_ITEMS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES,
    parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       btn_back,
    output logic [1:0] sel_idx,
    output logic       highlight_on,
    output logic       menu_active,
    output logic       start_pulse,
    output logic [1:0] game_mode
);

    localparam int FW = $clog2(CONFIRM_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [1:0]    LAST_IDX   = 2'(N_ITEMS - 1);
    localparam logic [FW-1:0] FRAMES_END = FW'(CONFIRM_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    menu_state_e   state_q, state_d;
    logic [1:0]    sel_idx_q, sel_idx_d;
    logic [1:0]    game_mode_q, game_mode_d;
    logic          highlight_q, highlight_d;
    logic          menu_active_q, menu_active_d;
    logic          start_pulse_q, start_pulse_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    logic vsync_q, enter_q, back_q;
    logic frame_tick, enter_press, back_press;
    logic up_press, down_press, up_step, down_step;
    logic any_press, rpt_clr;
    logic move_up, move_down;

    assign frame_tick  = vsync_in & ~vsync_q;
    assign enter_press = btn_enter & ~enter_q;
    assign back_press  = btn_back & ~back_q;
    assign any_press   = up_press | down_press | enter_press | back_press;
    // Auto-repeat only runs in MENU; any press restarts the hold timers.
    assign rpt_clr     = any_press | (state_q != MENU);

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rpt_up (
        .pclk       (pclk),
        .rst        (rst),
        .btn_lvl    (btn_up),
        .other_lvl  (btn_down),
        .frame_tick (frame_tick),
        .clr        (rpt_clr),
        .press      (up_press),
        .step       (up_step)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rpt_down (
        .pclk       (pclk),
        .rst        (rst),
        .btn_lvl    (btn_down),
        .other_lvl  (btn_up),
        .frame_tick (frame_tick),
        .clr        (rpt_clr),
        .press      (down_press),
        .step       (down_step)
    );

    // A move needs the opposite direction released; both held means no move.
    assign move_up   = (up_press | up_step) & ~btn_down;
    assign move_down = (down_press | down_step) & ~btn_up;

    // Flow FSM, cursor, blink timer and start pulse.
    always_comb begin
        state_d       = state_q;
        sel_idx_d     = sel_idx_q;
        game_mode_d   = game_mode_q;
        highlight_d   = highlight_q;
        start_pulse_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        blink_cnt_d   = blink_cnt_q;

        case (state_q)
            MENU: begin
                highlight_d = 1'b1;
                // Enter outranks any cursor move in the same cycle.
                if (enter_press) begin
                    game_mode_d = sel_idx_q;
                    frame_cnt_d = '0;
                    blink_cnt_d = '0;
                    state_d     = CONFIRM;
                end else if (move_up) begin
                    sel_idx_d = (sel_idx_q == 2'd0) ? LAST_IDX : sel_idx_q - 1'b1;
                end else if (move_down) begin
                    sel_idx_d = (sel_idx_q == LAST_IDX) ? 2'd0 : sel_idx_q + 1'b1;
                end
            end

            CONFIRM: begin
                if (back_press) begin
                    state_d     = MENU;
                    highlight_d = 1'b1;
                    frame_cnt_d = '0;
                    blink_cnt_d = '0;
                end else if (frame_tick) begin
                    if (frame_cnt_q != FRAMES_END) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (frame_cnt_d == FRAMES_END) begin
                        state_d       = RUN;
                        start_pulse_d = 1'b1;
                        highlight_d   = 1'b0;
                        frame_cnt_d   = '0;
                        blink_cnt_d   = '0;
                    end else if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        highlight_d = ~highlight_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end

            RUN: begin
                highlight_d = 1'b0;
                // Returning to the menu puts the cursor on the game just played.
                if (back_press) begin
                    state_d     = MENU;
                    sel_idx_d   = game_mode_q;
                    highlight_d = 1'b1;
                end
            end

            default: begin
                state_d     = MENU;
                highlight_d = 1'b1;
            end
        endcase

        menu_active_d = (state_d != RUN);
    end

    // Edge-detect copies and all registered state/outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            enter_q       <= 1'b0;
            back_q        <= 1'b0;
            state_q       <= MENU;
            sel_idx_q     <= 2'd0;
            game_mode_q   <= 2'd0;
            highlight_q   <= 1'b1;
            menu_active_q <= 1'b1;
            start_pulse_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
        end else begin
            vsync_q       <= vsync_in;
            enter_q       <= btn_enter;
            back_q        <= btn_back;
            state_q       <= state_d;
            sel_idx_q     <= sel_idx_d;
            game_mode_q   <= game_mode_d;
            highlight_q   <= highlight_d;
            menu_active_q <= menu_active_d;
            start_pulse_q <= start_pulse_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    assign sel_idx      = sel_idx_q;
    assign highlight_on = highlight_q;
    assign menu_active  = menu_active_q;
    assign start_pulse  = start_pulse_q;
    assign game_mode    = game_mode_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Bench for menu_ctrl: two instances (4 and 3 boxes) against a frame/press-level reference model.
// Latency: expected outputs for each clock edge are queued before it and compared just after it.
// Backpressure: none; the monitor consumes one expectation per instance per cycle.
module tb_menu_ctrl;

    localparam int DLY   = 30;
    localparam int RATE  = 6;
    localparam int BLINK = 8;
    localparam int CONF  = 64;
    localparam int B_UP = 0, B_DN = 1, B_ENT = 2, B_BACK = 3;

    logic       pclk = 1'b0;
    logic       rst, vsync_in, btn_up, btn_down, btn_enter, btn_back;
    logic [1:0] sel_a, gm_a, sel_b, gm_b;
    logic       hl_a, act_a, sp_a, hl_b, act_b, sp_b;

    always #5 pclk = ~pclk;

    menu_ctrl #(.N_ITEMS(4), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE),
                .BLINK_FRAMES(BLINK), .CONFIRM_FRAMES(CONF)) dut_a (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
        .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_back(btn_back),
        .sel_idx(sel_a), .highlight_on(hl_a), .menu_active(act_a),
        .start_pulse(sp_a), .game_mode(gm_a)
    );

    menu_ctrl #(.N_ITEMS(3), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE),
                .BLINK_FRAMES(BLINK), .CONFIRM_FRAMES(CONF)) dut_b (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
        .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_back(btn_back),
        .sel_idx(sel_b), .highlight_on(hl_b), .menu_active(act_b),
        .start_pulse(sp_b), .game_mode(gm_b)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       hl;
        logic       act;
        logic       sp;
        logic [1:0] gm;
    } outs_t;

    // mode: 0 menu, 1 confirming, 2 running. ticks: frames since enter.
    // hold: frames a single direction has been held since its last reset.
    typedef struct {
        int mode;
        int sel;
        int game;
        int ticks;
        int hold;
    } mdl_t;

    mdl_t  m [2];
    int    n_items [2];
    bit    pv, pu, pd, pe, pb;
    outs_t exp_a [$];
    outs_t exp_b [$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    // Reference model: one clock of behaviour for instance k, returns next outputs.
    function automatic outs_t model_one(input int k, input bit r, input bit tick,
                                        input bit up_p, input bit dn_p,
                                        input bit en_p, input bit bk_p);
        outs_t o;
        bit    start = 1'b0;
        bit    step  = 1'b0;
        bit    anyp;
        anyp = up_p | dn_p | en_p | bk_p;
        if (r) begin
            m[k] = '{0, 0, 0, 0, 0};
        end else begin
            case (m[k].mode)
                0: begin
                    if (anyp || (btn_up == btn_down)) begin
                        m[k].hold = 0;
                    end else if (tick) begin
                        m[k].hold = m[k].hold + 1;
                        step = (m[k].hold >= DLY) && (((m[k].hold - DLY) % RATE) == 0);
                    end
                    if (en_p) begin
                        m[k].game  = m[k].sel;
                        m[k].ticks = 0;
                        m[k].mode  = 1;
                    end else if (btn_up && !btn_down && (up_p || step)) begin
                        m[k].sel = (m[k].sel + n_items[k] - 1) % n_items[k];
                    end else if (btn_down && !btn_up && (dn_p || step)) begin
                        m[k].sel = (m[k].sel + 1) % n_items[k];
                    end
                end
                1: begin
                    m[k].hold = 0;
                    if (bk_p) begin
                        m[k].mode = 0;
                    end else if (tick) begin
                        m[k].ticks = m[k].ticks + 1;
                        if (m[k].ticks == CONF) begin
                            m[k].mode = 2;
                            start     = 1'b1;
                        end
                    end
                end
                default: begin
                    m[k].hold = 0;
                    if (bk_p) begin
                        m[k].mode = 0;
                        m[k].sel  = m[k].game;
                    end
                end
            endcase
        end
        o.sel = 2'(m[k].sel);
        o.gm  = 2'(m[k].game);
        o.act = (m[k].mode != 2);
        o.sp  = start;
        if (m[k].mode == 0)      o.hl = 1'b1;
        else if (m[k].mode == 2) o.hl = 1'b0;
        else                     o.hl = (((m[k].ticks / BLINK) % 2) == 0);
        return o;
    endfunction

    // Queue expectations for the coming edge, then advance one cycle.
    task automatic step_cyc();
        bit tick, up_p, dn_p, en_p, bk_p;
        tick = vsync_in && !pv;
        up_p = btn_up && !pu;
        dn_p = btn_down && !pd;
        en_p = btn_enter && !pe;
        bk_p = btn_back && !pb;
        exp_a.push_back(model_one(0, rst, tick, up_p, dn_p, en_p, bk_p));
        exp_b.push_back(model_one(1, rst, tick, up_p, dn_p, en_p, bk_p));
        if (rst) begin
            {pv, pu, pd, pe, pb} = '0;
        end else begin
            pv = vsync_in; pu = btn_up; pd = btn_down; pe = btn_enter; pb = btn_back;
        end
        @(negedge pclk);
    endtask

    // n frames of 4 cycles, rising vsync at the start of each.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1; step_cyc(); step_cyc();
            vsync_in = 1'b0; step_cyc(); step_cyc();
        end
    endtask

    // One-cycle tap of a button followed by gap idle cycles.
    task automatic tap(input int b, input int gap);
        case (b)
            B_UP:    btn_up    = 1'b1;
            B_DN:    btn_down  = 1'b1;
            B_ENT:   btn_enter = 1'b1;
            default: btn_back  = 1'b1;
        endcase
        step_cyc();
        {btn_up, btn_down, btn_enter, btn_back} = '0;
        repeat (gap) step_cyc();
    endtask

    task automatic check(input string nm, input outs_t e, input outs_t a);
        n_checks++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc %0d: got sel=%0d hl=%0b act=%0b sp=%0b gm=%0d, expected sel=%0d hl=%0b act=%0b sp=%0b gm=%0d",
                     nm, cyc, a.sel, a.hl, a.act, a.sp, a.gm, e.sel, e.hl, e.act, e.sp, e.gm);
        end
    endtask

    // Monitor: one comparison per instance per clock edge.
    initial begin
        outs_t e;
        forever begin
            @(posedge pclk);
            #1;
            cyc++;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("dut_n4", e, {sel_a, hl_a, act_a, sp_a, gm_a});
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("dut_n3", e, {sel_b, hl_b, act_b, sp_b, gm_b});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized levels.
    initial begin
        {vsync_in, btn_up, btn_down, btn_enter, btn_back} = '0;
        rst = 1'b1;
        m[0] = '{0, 0, 0, 0, 0};
        m[1] = '{0, 0, 0, 0, 0};
        n_items[0] = 4;
        n_items[1] = 3;
        {pv, pu, pd, pe, pb} = '0;

        repeat (3) step_cyc();
        rst = 1'b0;

        // Down presses 10 cycles apart, then back around to 0 and wrap up.
        for (int i = 0; i < 8; i++) tap(B_DN, 9);
        tap(B_UP, 5);

        // Both held together for 100 frames.
        btn_up = 1'b1; btn_down = 1'b1;
        frames(100);
        btn_up = 1'b0; btn_down = 1'b0;
        step_cyc();

        // Down held 42 frames, then up held 45 frames.
        btn_down = 1'b1; step_cyc(); frames(42);
        btn_down = 1'b0; repeat (3) step_cyc();
        btn_up = 1'b1; step_cyc(); frames(45);
        btn_up = 1'b0; step_cyc();

        // Press landing on a frame tick, then held.
        vsync_in = 1'b1; btn_down = 1'b1; step_cyc(); step_cyc();
        vsync_in = 1'b0; step_cyc();
        frames(33);
        btn_down = 1'b0; step_cyc();

        // Enter together with down: enter wins. Run to RUN, back out.
        btn_enter = 1'b1; btn_down = 1'b1; step_cyc();
        {btn_enter, btn_down} = '0;
        frames(70);
        tap(B_BACK, 3);

        // Enter at box 2, full confirm, back from RUN.
        for (int i = 0; i < 4 && m[0].sel != 2; i++) tap(B_DN, 2);
        tap(B_ENT, 2);
        frames(70);
        tap(B_BACK, 3);

        // Back and enter together in MENU, then back at confirm tick 20.
        btn_back = 1'b1; btn_enter = 1'b1; step_cyc();
        {btn_back, btn_enter} = '0;
        frames(20);
        tap(B_BACK, 3);

        // Reset at confirm tick 40; no start may follow.
        tap(B_DN, 2); tap(B_ENT, 2);
        frames(40);
        rst = 1'b1; step_cyc(); rst = 1'b0;
        frames(80);

        // Button held through reset release counts as a press.
        btn_down = 1'b1; rst = 1'b1; repeat (2) step_cyc();
        rst = 1'b0; step_cyc();
        btn_down = 1'b0; step_cyc();

        // Reset during RUN.
        tap(B_ENT, 2);
        frames(66);
        rst = 1'b1; step_cyc(); rst = 1'b0;
        repeat (4) step_cyc();

        // Randomized levels with random vsync.
        for (int i = 0; i < 6000; i++) begin
            vsync_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 149) == 0) btn_down  = ~btn_down;
            if ($urandom_range(0, 299) == 0) btn_enter = ~btn_enter;
            if ($urandom_range(0, 399) == 0) btn_back  = ~btn_back;
            rst = ($urandom_range(0, 1999) == 0);
            step_cyc();
        end
        rst = 1'b0;
        {btn_up, btn_down, btn_enter, btn_back} = '0;
        repeat (2) step_cyc();

        @(posedge pclk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
